// File: rtl/mux_arb.sv
// Round-robin N:1 arbiter/mux feeding a one-entry valid/ready output register.
// Optional MUX_ARB_LOCK_EN macro adds a lock input that keeps the grant on the last winner.
module mux_arb #(
    parameter int BIT_WIDTH = 4,
    parameter int DEPTH     = 4,
    parameter int SEL_WIDTH = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_n,
    input  logic [DEPTH-1:0]           req,
`ifdef MUX_ARB_LOCK_EN
    input  logic [DEPTH-1:0]           lock,
`endif
    input  logic [BIT_WIDTH*DEPTH-1:0] dataIn,
    output logic [DEPTH-1:0]           gnt,
    output logic [SEL_WIDTH-1:0]       sel,
    output logic [BIT_WIDTH-1:0]       dataOut,
    output logic                       out_valid,
    input  logic                       out_ready
);

    typedef struct packed {
        logic                 valid;
        logic [SEL_WIDTH-1:0] sel;
        logic [BIT_WIDTH-1:0] data;
    } out_t;

    out_t                              q;
    logic [SEL_WIDTH-1:0]              last;
    logic [SEL_WIDTH-1:0]              winner;
    logic [DEPTH-1:0]                  eligible;
    logic [DEPTH-1:0][BIT_WIDTH-1:0]   words;
    logic                              found;
    logic                              accept;
    logic                              room;
    logic                              load;

    assign words  = dataIn;
    assign accept = q.valid & out_ready;
    assign room   = ~q.valid | out_ready;

`ifdef MUX_ARB_LOCK_EN
    logic lock_q;

    // While locked only the previous winner may be granted again.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_elig
        assign eligible[gi] = req[gi] & (~lock_q | (last == SEL_WIDTH'(gi)));
    end

    // A locked grant always re-selects last, so the winner's lock bit decides the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      lock_q <= 1'b0;
        else if (load) lock_q <= lock[winner];
    end
`else
    assign eligible = req;
`endif

    // Search starts just after the previous winner and wraps.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (!found && eligible[(int'(last) + k) % DEPTH]) begin
                found  = 1'b1;
                winner = SEL_WIDTH'((int'(last) + k) % DEPTH);
            end
        end
    end

    // Gating with rst keeps gnt quiet for the whole reset window.
    assign load = rst & ~en_n & room & found;
    assign gnt  = load ? (DEPTH'(1) << winner) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= '0;
            last <= SEL_WIDTH'(DEPTH - 1);
        end else if (load) begin
            q    <= '{valid: 1'b1, sel: winner, data: words[winner]};
            last <= winner;
        end else if (accept) begin
            q.valid <= 1'b0;
        end
    end

    assign out_valid = q.valid;
    assign sel       = q.sel;
    assign dataOut   = q.data;

endmodule

// File: tb/tb_mux_arb.sv
// Bench for mux_arb (DEPTH=4, BIT_WIDTH=8): spec-level model checked every cycle
// plus directed literal checks of the covered scenarios.
module tb_mux_arb;
    localparam int BW = 8;
    localparam int DP = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_n;
    logic [DP-1:0] req;
    logic [BW*DP-1:0] dataIn;
    logic [DP-1:0] gnt;
    logic [SW-1:0] sel;
    logic [BW-1:0] dataOut;
    logic          out_valid;
    logic          out_ready;

    int n_chk  = 0;
    int n_fail = 0;

    mux_arb #(.BIT_WIDTH(BW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .en_n(en_n), .req(req), .dataIn(dataIn),
        .gnt(gnt), .sel(sel), .dataOut(dataOut), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model state: the word the consumer should see, and the priority pointer.
    logic          m_valid;
    logic [BW-1:0] m_data;
    int            m_sel;
    int            m_last;

    always @(negedge clk) begin
        int w;
        logic [DP-1:0] eg;
        if (!rst) begin
            chk("m_rst_valid", {31'b0, out_valid}, 0);
            chk("m_rst_data", {24'b0, dataOut}, 0);
            chk("m_rst_sel", {30'b0, sel}, 0);
            chk("m_rst_gnt", {28'b0, gnt}, 0);
            m_valid = 1'b0; m_data = '0; m_sel = 0; m_last = DP - 1;
        end else begin
            chk("m_valid", {31'b0, out_valid}, {31'b0, m_valid});
            chk("m_data", {24'b0, dataOut}, {24'b0, m_data});
            chk("m_sel", {30'b0, sel}, m_sel);
            w = -1;
            if (!en_n && (!m_valid || out_ready))
                for (int k = 1; k <= DP; k++)
                    if (w < 0 && req[(m_last + k) % DP]) w = (m_last + k) % DP;
            eg = (w >= 0) ? DP'(1 << w) : '0;
            chk("m_gnt", {28'b0, gnt}, {28'b0, eg});
            if (w >= 0) begin
                m_valid = 1'b1;
                m_data  = BW'(dataIn >> (BW * w));
                m_sel   = w;
                m_last  = w;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; en_n = 1'b1; req = '0; out_ready = 1'b0;
        dataIn = 32'hA3A2A1A0;
        cyc(); cyc();
        #2;
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_data", {24'b0, dataOut}, 0);
        chk("rst_gnt", {28'b0, gnt}, 0);
        cyc();
        rst = 1'b1;

        // Full request, consumer always ready: rotate 0,1,2,3,0.
        cyc(); req = 4'b1111; out_ready = 1'b1; en_n = 1'b0; #2;
        chk("rr_gnt0", {28'b0, gnt}, 32'h1);
        cyc(); #2; chk("rr_gnt1", {28'b0, gnt}, 32'h2); chk("rr_d0", {24'b0, dataOut}, 32'hA0);
        cyc(); #2; chk("rr_gnt2", {28'b0, gnt}, 32'h4); chk("rr_d1", {24'b0, dataOut}, 32'hA1);
        cyc(); #2; chk("rr_gnt3", {28'b0, gnt}, 32'h8); chk("rr_d2", {24'b0, dataOut}, 32'hA2);
        cyc(); #2; chk("rr_gnt4", {28'b0, gnt}, 32'h1); chk("rr_d3", {24'b0, dataOut}, 32'hA3);

        // Drain, then a single requester against a stalled consumer.
        cyc(); req = '0;
        cyc(); req = 4'b0100; out_ready = 1'b0; #2;
        chk("stall_gnt", {28'b0, gnt}, 32'h4);
        for (int i = 0; i < 3; i++) begin
            cyc(); #2;
            chk("stall_hold_gnt", {28'b0, gnt}, 0);
            chk("stall_data", {24'b0, dataOut}, 32'hA2);
            chk("stall_sel", {30'b0, sel}, 2);
            chk("stall_valid", {31'b0, out_valid}, 1);
        end
        out_ready = 1'b1; #1;
        chk("b2b_gnt", {28'b0, gnt}, 32'h4);

        // Disable blocks loads but still drains; resumes after last winner (2).
        cyc(); en_n = 1'b1; req = 4'b1111; #2;
        chk("dis_gnt", {28'b0, gnt}, 0);
        cyc(); #2;
        chk("dis_drain", {31'b0, out_valid}, 0);
        chk("dis_gnt2", {28'b0, gnt}, 0);
        en_n = 1'b0; #1;
        chk("resume_gnt", {28'b0, gnt}, 32'h8);
        cyc(); #2;
        chk("resume_sel", {30'b0, sel}, 3);
        chk("resume_data", {24'b0, dataOut}, 32'hA3);

        // Fresh data pattern, sparse request.
        cyc(); req = 4'b1010; dataIn = 32'h44332211; #2;
        chk("sparse_gnt", {28'b0, gnt}, 32'h2);
        cyc(); #2;
        chk("sparse_data", {24'b0, dataOut}, 32'h22);

        // Reset while a word is stuck at the output.
        out_ready = 1'b0; req = 4'b1111;
        cyc(); #2;
        chk("pre_rst_valid", {31'b0, out_valid}, 1);
        rst = 1'b0; #1;
        chk("arst_valid", {31'b0, out_valid}, 0);
        chk("arst_data", {24'b0, dataOut}, 0);
        chk("arst_gnt", {28'b0, gnt}, 0);
        cyc(); rst = 1'b1; #2;
        chk("post_rst_gnt", {28'b0, gnt}, 32'h1);

        cyc(); out_ready = 1'b1; req = '0;
        cyc(); cyc(); cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
